// File: rtl/ysyx_23060278_alu_arb_if.sv
// Bundle of request/response handshakes between two requesters and the shared-ALU arbiter.
interface ysyx_23060278_alu_arb_if;
  logic        req_valid_0;
  logic        req_valid_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic [31:0] opdata1_0;
  logic [31:0] opdata1_1;
  logic [31:0] opdata2_0;
  logic [31:0] opdata2_1;
  logic [2:0]  aluctl_0;
  logic [2:0]  aluctl_1;
  logic        resp_valid_0;
  logic        resp_valid_1;
  logic        resp_ready_0;
  logic        resp_ready_1;
  logic [31:0] result;
  logic        busy;

  modport slave (
    input  req_valid_0, req_valid_1, opdata1_0, opdata1_1, opdata2_0, opdata2_1,
    input  aluctl_0, aluctl_1, resp_ready_0, resp_ready_1,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, result, busy
  );

  modport master (
    output req_valid_0, req_valid_1, opdata1_0, opdata1_1, opdata2_0, opdata2_1,
    output aluctl_0, aluctl_1, resp_ready_0, resp_ready_1,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, result, busy
  );
endinterface

// File: rtl/ysyx_23060278_alu_arb.sv
// Two-requester arbiter sharing a single ALU: IDLE grants, EXEC computes, RESP holds the result
// until the owning requester consumes it.
module ysyx_23060278_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctl,
  output logic [31:0] y
);
  always_comb begin
    case (ctl)
      3'b000, 3'b001: y = a + b;
      3'b010:         y = a & b;
      3'b011:         y = a | b;
      default:        y = 32'h0;
    endcase
  end
endmodule

module ysyx_23060278_alu_arb #(
  parameter int unsigned NREQ = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_23060278_alu_arb_if.slave   bus
);
  if (NREQ != 2) begin : g_nreq_check
    $fatal(1, "ysyx_23060278_alu_arb supports only NREQ == 2");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        prio_q;
  logic        owner_q;
  logic [31:0] op1_q, op2_q;
  logic [2:0]  ctl_q;
  logic [31:0] result_q;
  logic [31:0] alu_out;
  logic        grant_0, grant_1;
  logic        ready_0, ready_1;
  logic        handshake;
  logic        ack;

  // prio names the requester that wins a tie
  assign grant_0 = bus.req_valid_0 & (~bus.req_valid_1 | ~prio_q);
  assign grant_1 = bus.req_valid_1 & (~bus.req_valid_0 |  prio_q);

  assign ready_0   = (state_q == IDLE) & grant_0 & ~rst;
  assign ready_1   = (state_q == IDLE) & grant_1 & ~rst;
  assign handshake = ready_0 | ready_1;
  assign ack       = owner_q ? bus.resp_ready_1 : bus.resp_ready_0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
      ctl_q    <= 3'b000;
      result_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        owner_q <= ready_1;
        prio_q  <= ~ready_1;
        op1_q   <= ready_1 ? bus.opdata1_1 : bus.opdata1_0;
        op2_q   <= ready_1 ? bus.opdata2_1 : bus.opdata2_0;
        ctl_q   <= ready_1 ? bus.aluctl_1  : bus.aluctl_0;
      end
      if (state_q == EXEC) result_q <= alu_out;
    end
  end

  ysyx_23060278_alu u_alu (
    .a   (op1_q),
    .b   (op2_q),
    .ctl (ctl_q),
    .y   (alu_out)
  );

  assign bus.req_ready_0  = ready_0;
  assign bus.req_ready_1  = ready_1;
  assign bus.resp_valid_0 = (state_q == RESP) & ~owner_q;
  assign bus.resp_valid_1 = (state_q == RESP) &  owner_q;
  assign bus.result       = result_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_23060278_alu_arb.sv
// Directed bench for the shared-ALU arbiter: reset, single ops, contention, back-pressure,
// illegal opcode, reset mid-operation and alternating grants.
module tb_ysyx_23060278_alu_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_23060278_alu_arb_if bus ();

  ysyx_23060278_alu_arb #(.NREQ(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid_0 = 0; bus.req_valid_1 = 0;
    bus.opdata1_0 = 0; bus.opdata2_0 = 0; bus.aluctl_0 = 0;
    bus.opdata1_1 = 0; bus.opdata2_1 = 0; bus.aluctl_1 = 0;
    bus.resp_ready_0 = 0; bus.resp_ready_1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    // Reset, with both requesters asserting valid while rst is high
    bus.req_valid_0 = 1; bus.req_valid_1 = 1;
    tick();
    tick();
    chk("rst_ready0", {31'b0, bus.req_ready_0}, 0);
    chk("rst_ready1", {31'b0, bus.req_ready_1}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_rv0", {31'b0, bus.resp_valid_0}, 0);
    chk("rst_rv1", {31'b0, bus.resp_valid_1}, 0);
    chk("rst_result", bus.result, 32'h0);
    bus.req_valid_0 = 0; bus.req_valid_1 = 0;
    rst = 1'b0;

    // Single add with wraparound
    bus.req_valid_0 = 1; bus.opdata1_0 = 32'hFFFF_FFFF; bus.opdata2_0 = 32'h1; bus.aluctl_0 = 3'b000;
    #1;
    chk("add_ready0", {31'b0, bus.req_ready_0}, 1);
    chk("add_ready1", {31'b0, bus.req_ready_1}, 0);
    tick();
    bus.req_valid_0 = 0;
    chk("add_exec_busy", {31'b0, bus.busy}, 1);
    chk("add_exec_rv0", {31'b0, bus.resp_valid_0}, 0);
    tick();
    chk("add_rv0", {31'b0, bus.resp_valid_0}, 1);
    chk("add_rv1", {31'b0, bus.resp_valid_1}, 0);
    chk("add_result", bus.result, 32'h0);
    bus.resp_ready_0 = 1;
    tick();
    bus.resp_ready_0 = 0;
    chk("add_done_busy", {31'b0, bus.busy}, 0);

    // Contention straight after reset: requester 0 first, requester 1 next
    do_reset();
    bus.req_valid_0 = 1; bus.opdata1_0 = 32'd5; bus.opdata2_0 = 32'd7; bus.aluctl_0 = 3'b001;
    bus.req_valid_1 = 1; bus.opdata1_1 = 32'hF0F0_0000; bus.opdata2_1 = 32'hFF00_FF00;
    bus.aluctl_1 = 3'b010;
    #1;
    chk("cont_ready0", {31'b0, bus.req_ready_0}, 1);
    chk("cont_ready1", {31'b0, bus.req_ready_1}, 0);
    tick();
    chk("cont_exec_ready1", {31'b0, bus.req_ready_1}, 0);
    tick();
    chk("cont_rv0", {31'b0, bus.resp_valid_0}, 1);
    chk("cont_rv1", {31'b0, bus.resp_valid_1}, 0);
    chk("cont_result0", bus.result, 32'd12);
    bus.resp_ready_1 = 1;  // non-owner ready must not complete the response
    tick();
    bus.resp_ready_1 = 0;
    chk("cont_nonowner_rv0", {31'b0, bus.resp_valid_0}, 1);
    chk("cont_nonowner_busy", {31'b0, bus.busy}, 1);
    bus.resp_ready_0 = 1;
    tick();
    bus.resp_ready_0 = 0;
    chk("cont_idle_ready1", {31'b0, bus.req_ready_1}, 1);
    chk("cont_idle_ready0", {31'b0, bus.req_ready_0}, 0);
    tick();
    bus.req_valid_1 = 0;
    tick();
    chk("cont_rv1_b", {31'b0, bus.resp_valid_1}, 1);
    chk("cont_rv0_b", {31'b0, bus.resp_valid_0}, 0);
    chk("cont_result1", bus.result, 32'hF000_0000);
    bus.resp_ready_1 = 1;
    tick();
    bus.resp_ready_1 = 0;

    // Back-pressure on requester 0 while requester 1 waits
    bus.req_valid_0 = 1; bus.opdata1_0 = 32'h0000_00FF; bus.opdata2_0 = 32'h0000_FF00;
    bus.aluctl_0 = 3'b011;
    bus.req_valid_1 = 1; bus.opdata1_1 = 32'd1; bus.opdata2_1 = 32'd1; bus.aluctl_1 = 3'b000;
    #1;
    chk("bp_ready0", {31'b0, bus.req_ready_0}, 1);
    tick();
    bus.req_valid_0 = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", bus.result, 32'h0000_FFFF);
      chk("bp_busy", {31'b0, bus.busy}, 1);
      chk("bp_ready1", {31'b0, bus.req_ready_1}, 0);
      chk("bp_rv0", {31'b0, bus.resp_valid_0}, 1);
      tick();
    end
    bus.resp_ready_0 = 1;
    #1;
    chk("bp_hold_result", bus.result, 32'h0000_FFFF);
    tick();
    bus.resp_ready_0 = 0;
    chk("bp_after_ready1", {31'b0, bus.req_ready_1}, 1);
    bus.req_valid_1 = 0;
    #1;

    // Illegal opcode yields zero
    bus.req_valid_0 = 1; bus.opdata1_0 = 32'h1234_5678; bus.opdata2_0 = 32'h1; bus.aluctl_0 = 3'b111;
    #1;
    chk("ill_ready0", {31'b0, bus.req_ready_0}, 1);
    tick();
    bus.req_valid_0 = 0;
    tick();
    chk("ill_rv0", {31'b0, bus.resp_valid_0}, 1);
    chk("ill_result", bus.result, 32'h0);
    bus.resp_ready_0 = 1;
    tick();
    bus.resp_ready_0 = 0;
    chk("ill_done_busy", {31'b0, bus.busy}, 0);

    // Reset pulsed during EXEC discards the operation
    bus.req_valid_1 = 1; bus.opdata1_1 = 32'd1; bus.opdata2_1 = 32'd2; bus.aluctl_1 = 3'b000;
    #1;
    chk("rmid_ready1", {31'b0, bus.req_ready_1}, 1);
    tick();
    bus.req_valid_1 = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_busy", {31'b0, bus.busy}, 0);
    chk("rmid_rv0", {31'b0, bus.resp_valid_0}, 0);
    chk("rmid_rv1", {31'b0, bus.resp_valid_1}, 0);
    chk("rmid_result", bus.result, 32'h0);
    tick();
    chk("rmid_rv1_late", {31'b0, bus.resp_valid_1}, 0);
    bus.req_valid_0 = 1; bus.opdata1_0 = 32'd10; bus.opdata2_0 = 32'd20; bus.aluctl_0 = 3'b000;
    bus.req_valid_1 = 1;
    #1;
    chk("rmid_prio_ready0", {31'b0, bus.req_ready_0}, 1);
    chk("rmid_prio_ready1", {31'b0, bus.req_ready_1}, 0);
    tick();
    bus.req_valid_0 = 0; bus.req_valid_1 = 0;
    tick();
    chk("rmid_fresh_rv0", {31'b0, bus.resp_valid_0}, 1);
    chk("rmid_fresh_result", bus.result, 32'd30);
    bus.resp_ready_0 = 1;
    tick();
    bus.resp_ready_0 = 0;

    // Fairness: both held valid, responses consumed immediately
    do_reset();
    bus.req_valid_0 = 1; bus.opdata1_0 = 32'd100; bus.opdata2_0 = 32'd1; bus.aluctl_0 = 3'b000;
    bus.req_valid_1 = 1; bus.opdata1_1 = 32'hF0; bus.opdata2_1 = 32'h0F; bus.aluctl_1 = 3'b011;
    bus.resp_ready_0 = 1; bus.resp_ready_1 = 1;
    #1;
    for (int c = 0; c < 12; c++) begin
      automatic logic odd = ((c / 3) % 2) == 1;
      if (c % 3 == 0) begin
        chk("fair_ready0", {31'b0, bus.req_ready_0}, {31'b0, ~odd});
        chk("fair_ready1", {31'b0, bus.req_ready_1}, {31'b0, odd});
      end else if (c % 3 == 2) begin
        chk("fair_rv0", {31'b0, bus.resp_valid_0}, {31'b0, ~odd});
        chk("fair_rv1", {31'b0, bus.resp_valid_1}, {31'b0, odd});
        chk("fair_result", bus.result, odd ? 32'hFF : 32'd101);
      end else begin
        chk("fair_exec_busy", {31'b0, bus.busy}, 1);
      end
      tick();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
